comp_scheduler: RTL

- Sequencing controller for the fingerprint comparison register file (head/tail pointers, fprints_ready).
- Selects a task whose fingerprints are ready on both logical cores (round-robin), drives comp_task, and reads paired fingerprints from CRC RAM at the two tail pointers.
- Compares the pair, then advances the tails or resets the task on mismatch.
- Reports each task verdict through a status handshake to the monitor processor.

---
 rtl/comp_scheduler_pkg.sv | 25 ++
 rtl/comp_scheduler_rr_task_arbiter.sv | 29 ++
 rtl/comp_scheduler.sv | 141 ++++++++++++++
 3 files changed

// File: rtl/comp_scheduler_pkg.sv
// Shared CRC register-file dimensions, scheduler state encoding and verdict record
// used by the fingerprint comparison scheduler.
package comp_scheduler_pkg;

    localparam int CRC_KEY_WIDTH         = 4;
    localparam int CRC_KEY_SIZE          = 1 << CRC_KEY_WIDTH;
    localparam int CRC_RAM_ADDRESS_WIDTH = 8;
    localparam int FP_WIDTH_DEFAULT      = 32;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETTLE,
        ST_CHECK,
        ST_READ,
        ST_WAIT,
        ST_COMPARE,
        ST_REQ_RESET
    } state_t;

    typedef struct packed {
        logic [CRC_KEY_WIDTH-1:0] task_id;
        logic                     mismatch;
    } verdict_t;

endpackage

// File: rtl/comp_scheduler_rr_task_arbiter.sv
// Combinational round-robin find-first-set over the per-task ready vector,
// starting one past the most recent grant and wrapping around.
module comp_scheduler_rr_task_arbiter
    import comp_scheduler_pkg::*;
(
    input  logic [CRC_KEY_SIZE-1:0]  req,
    input  logic [CRC_KEY_WIDTH-1:0] rr_last,
    output logic [CRC_KEY_WIDTH-1:0] grant,
    output logic                     grant_valid
);

    logic [CRC_KEY_WIDTH-1:0] idx;

    // Scan from farthest to nearest so the nearest set bit wins; the key-width
    // add wraps naturally because CRC_KEY_SIZE is a power of two.
    always_comb begin
        grant       = '0;
        grant_valid = 1'b0;
        idx         = '0;
        for (int i = CRC_KEY_SIZE; i >= 1; i--) begin
            idx = rr_last + CRC_KEY_WIDTH'(i);
            if (req[idx]) begin
                grant       = idx;
                grant_valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/comp_scheduler.sv
// Fingerprint comparison sequencer: grants a ready task, walks paired CRC RAM
// entries at the two tails, and reports a match/mismatch verdict per task.
module comp_scheduler
    import comp_scheduler_pkg::*;
#(
    parameter int FP_WIDTH    = FP_WIDTH_DEFAULT,
    parameter int RAM_LATENCY = 1,
    parameter int MAX_BURST   = 8
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             enable,
    input  logic [CRC_KEY_SIZE-1:0]          fprints_ready,
    input  logic                             head0_matches_head1,
    input  logic                             tail0_matches_head0,
    input  logic                             tail1_matches_head1,
    input  logic [CRC_RAM_ADDRESS_WIDTH-1:0] comp_tail_pointer0,
    input  logic [CRC_RAM_ADDRESS_WIDTH-1:0] comp_tail_pointer1,
    input  logic                             reset_fprint_ack,
    output logic [CRC_KEY_WIDTH-1:0]         comp_task,
    output logic                             comp_increment_tail_pointer,
    output logic                             comp_reset_fprint_ready,
    output logic                             comp_mismatch_detected,
    output logic                             ram_rd_en,
    output logic [CRC_RAM_ADDRESS_WIDTH-1:0] ram_rd_addr0,
    output logic [CRC_RAM_ADDRESS_WIDTH-1:0] ram_rd_addr1,
    input  logic [FP_WIDTH-1:0]              ram_rd_data0,
    input  logic [FP_WIDTH-1:0]              ram_rd_data1,
    output logic                             status_valid,
    output logic [CRC_KEY_WIDTH-1:0]         status_task,
    output logic                             status_mismatch,
    input  logic                             status_ack
);

    localparam int BURST_W = $clog2(MAX_BURST + 1);

    state_t                   state, state_nxt;
    logic [CRC_KEY_WIDTH-1:0] rr_last, grant;
    logic                     grant_valid;
    logic [BURST_W-1:0]       burst;
    logic                     mismatch_q;
    logic [FP_WIDTH-1:0]      fp0_q, fp1_q;
    logic [RAM_LATENCY-1:0]   vld_pipe;
    verdict_t                 verdict_q;
    logic                     take_grant, stream_done, data_eq;

    comp_scheduler_rr_task_arbiter u_arb (
        .req         (fprints_ready),
        .rr_last     (rr_last),
        .grant       (grant),
        .grant_valid (grant_valid)
    );

    assign take_grant   = (state == ST_IDLE) && enable && !status_valid && grant_valid;
    assign stream_done  = tail0_matches_head0 && tail1_matches_head1 && head0_matches_head1;
    assign data_eq      = (fp0_q == fp1_q);
    assign ram_rd_addr0 = comp_tail_pointer0;
    assign ram_rd_addr1 = comp_tail_pointer1;
    assign status_task     = verdict_q.task_id;
    assign status_mismatch = verdict_q.mismatch;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= ST_IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt                   = state;
        comp_increment_tail_pointer = 1'b0;
        comp_reset_fprint_ready     = 1'b0;
        comp_mismatch_detected      = 1'b0;
        ram_rd_en                   = 1'b0;
        case (state)
            ST_IDLE:   if (take_grant) state_nxt = ST_SETTLE;
            ST_SETTLE: state_nxt = ST_CHECK;
            ST_CHECK: begin
                if (stream_done)                                     state_nxt = ST_REQ_RESET;
                else if (tail0_matches_head0 || tail1_matches_head1) state_nxt = ST_IDLE;
                else if (burst == BURST_W'(MAX_BURST))               state_nxt = ST_IDLE;
                else                                                 state_nxt = ST_READ;
            end
            ST_READ: begin
                ram_rd_en = 1'b1;
                state_nxt = ST_WAIT;
            end
            ST_WAIT:   if (vld_pipe[RAM_LATENCY-1]) state_nxt = ST_COMPARE;
            ST_COMPARE: begin
                if (data_eq) begin
                    comp_increment_tail_pointer = 1'b1;
                    state_nxt                   = ST_SETTLE;
                end else begin
                    state_nxt = ST_REQ_RESET;
                end
            end
            ST_REQ_RESET: begin
                comp_reset_fprint_ready = 1'b1;
                comp_mismatch_detected  = mismatch_q;
                if (reset_fprint_ack) state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Read data is latched on the cycle the latency pipe says it is valid,
    // so the compare never depends on the RAM holding its output.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            comp_task    <= '0;
            rr_last      <= CRC_KEY_WIDTH'(CRC_KEY_SIZE - 1);
            burst        <= '0;
            mismatch_q   <= 1'b0;
            fp0_q        <= '0;
            fp1_q        <= '0;
            vld_pipe     <= '0;
            verdict_q    <= '0;
            status_valid <= 1'b0;
        end else begin
            vld_pipe <= (vld_pipe << 1) | RAM_LATENCY'(ram_rd_en);
            if (take_grant) begin
                comp_task <= grant;
                rr_last   <= grant;
                burst     <= '0;
            end
            if (state == ST_CHECK) mismatch_q <= 1'b0;
            if (state == ST_WAIT && vld_pipe[RAM_LATENCY-1]) begin
                fp0_q <= ram_rd_data0;
                fp1_q <= ram_rd_data1;
            end
            if (state == ST_COMPARE) begin
                if (!data_eq)                            mismatch_q <= 1'b1;
                else if (burst != BURST_W'(MAX_BURST))   burst      <= burst + 1'b1;
            end
            if (status_valid && status_ack) status_valid <= 1'b0;
            if (state == ST_REQ_RESET && reset_fprint_ack) begin
                verdict_q    <= '{task_id: comp_task, mismatch: mismatch_q};
                status_valid <= 1'b1;
            end
        end
    end

endmodule
